// File: rtl/cpunet_rxfilter.sv
// Receive-side MAC filter for the CPU network path: a programmable destination-address
// table plus broadcast/multicast/promiscuous rules, with Wishbone-readable statistics.
module cpunet_rxfilter #(
    parameter int          PKTDW             = 128,
    parameter int          NMAC              = 4,
    parameter logic [47:0] DEF_MAC           = 48'h1434_afa8_1234,
    parameter bit          OPT_LITTLE_ENDIAN = 1'b0,
    localparam int         AW                = $clog2(NMAC) + 2,
    localparam int         BW                = $clog2(PKTDW/8)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [AW-1:0]    i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic             S_AXIN_VALID,
    output logic             S_AXIN_READY,
    input  logic             S_AXIN_LAST,
    input  logic             S_AXIN_ABORT,
    input  logic [PKTDW-1:0] S_AXIN_DATA,
    input  logic [BW-1:0]    S_AXIN_BYTES,
    output logic             M_AXIN_VALID,
    input  logic             M_AXIN_READY,
    output logic             M_AXIN_LAST,
    output logic             M_AXIN_ABORT,
    output logic [PKTDW-1:0] M_AXIN_DATA,
    output logic [BW-1:0]    M_AXIN_BYTES
);
    localparam int IW = $clog2(NMAC);

    // state | meaning
    // IDLE  | waiting for the first beat of a packet; decision made on that beat
    // PASS  | packet matched; beats forwarded until LAST or abort
    // DROP  | packet rejected; beats swallowed until LAST or abort
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NMAC-1:0]  en_q;
    logic [47:0]      mac_q [NMAC];
    logic [2:0]       ctrl_q;
    logic [31:0]      acc_cnt_q, drp_cnt_q, abt_cnt_q;
    logic             wb_ack_q;
    logic [31:0]      wb_data_q;
    logic             m_valid_q, m_last_q, m_abort_q;
    logic [PKTDW-1:0] m_data_q;
    logic [BW-1:0]    m_bytes_q;

    logic [IW-1:0] wb_idx;
    logic          wb_req, wb_wr, wb_reg;
    logic          wr_ctrl, wr_acc, wr_drp, wr_abt;
    logic [31:0]   rd_data;

    assign wb_idx  = i_wb_addr[AW-2:1];
    assign wb_req  = i_wb_cyc && i_wb_stb;
    assign wb_wr   = wb_req && i_wb_we;
    assign wb_reg  = i_wb_addr[AW-1];
    assign wr_ctrl = wb_wr && wb_reg && (i_wb_addr[1:0] == 2'd0);
    assign wr_acc  = wb_wr && wb_reg && (i_wb_addr[1:0] == 2'd1);
    assign wr_drp  = wb_wr && wb_reg && (i_wb_addr[1:0] == 2'd2);
    assign wr_abt  = wb_wr && wb_reg && (i_wb_addr[1:0] == 2'd3);

    logic [47:0] da;
    logic        tbl_hit, match, runt, in_fire;
    logic        fwd, abort_out, inc_acc, inc_drp, inc_abt;

    // DA is assembled with the first wire octet in da[47:40] regardless of lane order
    always_comb begin
        da = 48'h0;
        for (int i = 0; i < 6; i++) begin
            if (OPT_LITTLE_ENDIAN)
                da[47-8*i -: 8] = S_AXIN_DATA[8*i +: 8];
            else
                da[47-8*i -: 8] = S_AXIN_DATA[PKTDW-1-8*i -: 8];
        end
    end

    always_comb begin
        tbl_hit = 1'b0;
        for (int k = 0; k < NMAC; k++) begin
            if (en_q[k] && (da == mac_q[k]))
                tbl_hit = 1'b1;
        end
    end

    assign match   = ctrl_q[2] || ((&da) && ctrl_q[0]) || (da[40] && ctrl_q[1]) || tbl_hit;
    assign runt    = S_AXIN_LAST && (S_AXIN_BYTES != '0) && (S_AXIN_BYTES < BW'(6));
    assign S_AXIN_READY = (state_q == ST_DROP) || !m_valid_q || M_AXIN_READY;
    assign in_fire = S_AXIN_VALID && S_AXIN_READY;

    always_comb begin
        state_d   = state_q;
        fwd       = 1'b0;
        abort_out = 1'b0;
        inc_acc   = 1'b0;
        inc_drp   = 1'b0;
        inc_abt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (match && !runt) begin
                        fwd = 1'b1;
                        if (S_AXIN_LAST) inc_acc = 1'b1;
                        else             state_d = ST_PASS;
                    end else begin
                        if (S_AXIN_LAST) inc_drp = 1'b1;
                        else             state_d = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                if (S_AXIN_ABORT) begin
                    abort_out = 1'b1;
                    inc_abt   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (in_fire) begin
                    fwd = 1'b1;
                    if (S_AXIN_LAST) begin
                        inc_acc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (S_AXIN_ABORT || (in_fire && S_AXIN_LAST)) begin
                    inc_drp = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_abort_q <= 1'b0;
            m_data_q  <= '0;
            m_bytes_q <= '0;
        end else if (abort_out) begin
            m_valid_q <= 1'b0;
            m_abort_q <= 1'b1;
        end else begin
            m_abort_q <= 1'b0;
            if (fwd) begin
                m_valid_q <= 1'b1;
                m_data_q  <= S_AXIN_DATA;
                m_bytes_q <= S_AXIN_BYTES;
                m_last_q  <= S_AXIN_LAST;
            end else if (M_AXIN_READY) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign M_AXIN_VALID = m_valid_q;
    assign M_AXIN_LAST  = m_last_q;
    assign M_AXIN_ABORT = m_abort_q;
    assign M_AXIN_DATA  = m_data_q;
    assign M_AXIN_BYTES = m_bytes_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            en_q <= NMAC'(1);
            for (int k = 0; k < NMAC; k++)
                mac_q[k] <= (k == 0) ? DEF_MAC : 48'h0;
        end else if (wb_wr && !wb_reg) begin
            if (!i_wb_addr[0]) begin
                if (i_wb_sel[3]) en_q[wb_idx]         <= i_wb_data[31];
                if (i_wb_sel[1]) mac_q[wb_idx][47:40] <= i_wb_data[15:8];
                if (i_wb_sel[0]) mac_q[wb_idx][39:32] <= i_wb_data[7:0];
            end else begin
                if (i_wb_sel[3]) mac_q[wb_idx][31:24] <= i_wb_data[31:24];
                if (i_wb_sel[2]) mac_q[wb_idx][23:16] <= i_wb_data[23:16];
                if (i_wb_sel[1]) mac_q[wb_idx][15:8]  <= i_wb_data[15:8];
                if (i_wb_sel[0]) mac_q[wb_idx][7:0]   <= i_wb_data[7:0];
            end
        end
    end

    // A register write in the same cycle as a counter event takes priority
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q    <= 3'b001;
            acc_cnt_q <= 32'h0;
            drp_cnt_q <= 32'h0;
            abt_cnt_q <= 32'h0;
        end else begin
            if (wr_ctrl && i_wb_sel[0]) ctrl_q <= i_wb_data[2:0];
            if (wr_acc)       acc_cnt_q <= 32'h0;
            else if (inc_acc) acc_cnt_q <= acc_cnt_q + 32'd1;
            if (wr_drp)       drp_cnt_q <= 32'h0;
            else if (inc_drp) drp_cnt_q <= drp_cnt_q + 32'd1;
            if (wr_abt)       abt_cnt_q <= 32'h0;
            else if (inc_abt) abt_cnt_q <= abt_cnt_q + 32'd1;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (!wb_reg) begin
            if (i_wb_addr[0]) rd_data = mac_q[wb_idx][31:0];
            else              rd_data = {en_q[wb_idx], 15'h0, mac_q[wb_idx][47:32]};
        end else begin
            case (i_wb_addr[1:0])
                2'd0:    rd_data = {29'h0, ctrl_q};
                2'd1:    rd_data = acc_cnt_q;
                2'd2:    rd_data = drp_cnt_q;
                default: rd_data = abt_cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_ack_q  <= 1'b0;
            wb_data_q <= 32'h0;
        end else begin
            wb_ack_q  <= wb_req;
            wb_data_q <= (wb_req && !i_wb_we) ? rd_data : 32'h0;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = wb_ack_q;
    assign o_wb_data  = wb_data_q;

endmodule
